// File: rtl/sort_engine_pkg.sv
// rtl/sort_engine_pkg.sv - shared types and default widths for the sort engine packet sender
package sort_engine_pkg;

  localparam int SORT_AWIDTH = 5;
  localparam int SORT_DWIDTH = 8;

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    HOLD    = 3'd1,
    SEND    = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } sender_state_t;

endpackage

// File: rtl/sort_engine_if.sv
// rtl/sort_engine_if.sv - sop/eop/val/data packet bus with busy back-indication
interface sort_engine_if #(parameter int DWIDTH = 8);
  logic              sop;
  logic              eop;
  logic              val;
  logic [DWIDTH-1:0] data;
  logic              busy;

  modport master (output sop, output eop, output val, output data, input busy);
  modport slave  (input sop, input eop, input val, input data, output busy);
endinterface

// File: rtl/sort_pkt_buf.sv
// rtl/sort_pkt_buf.sv - simple dual-port packet buffer, one write port and one registered read port
module sort_pkt_buf
  import sort_engine_pkg::*;
#(
  parameter int AWIDTH = SORT_AWIDTH,
  parameter int DWIDTH = SORT_DWIDTH
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AWIDTH-1:0] rd_addr_i,
  output logic [DWIDTH-1:0] rd_data_o
);

  logic [DWIDTH-1:0] mem_q [0:(1<<AWIDTH)-1];
  logic [DWIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sort_pkt_sender.sv
// rtl/sort_pkt_sender.sv - buffers one packet, sends it to the sort engine, waits for drain
// Optional statistics counters enabled by SORT_PKT_SENDER_STATS_EN.
module sort_pkt_sender
  import sort_engine_pkg::*;
#(
  parameter int AWIDTH = SORT_AWIDTH,
  parameter int DWIDTH = SORT_DWIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_req_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              wr_last_i,
  output logic              ready_o,
  output logic              done_o,
`ifdef SORT_PKT_SENDER_STATS_EN
  output logic [15:0]       pkt_cnt_o,
  output logic [15:0]       drop_cnt_o,
`endif
  sort_engine_if.master     pkt_o
);

  localparam logic [AWIDTH:0] FULL = (AWIDTH+1)'(1 << AWIDTH);

  sender_state_t     state_q, state_d;
  logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              rd_vld_q, rd_first_q, rd_first_d, rd_last_q, rd_last_d;
  logic              sop_q, eop_q, val_q;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              accept, wr_en, rd_en;
  logic [AWIDTH-1:0] rd_addr;
  logic [DWIDTH-1:0] rd_data;

  assign accept = wr_req_i & ready_q;

  sort_pkt_buf #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_buf (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q[AWIDTH-1:0]),
    .wr_data_i (wr_data_i),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = rd_ptr_q[AWIDTH-1:0];
    rd_first_d = 1'b0;
    rd_last_d  = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      LOAD: begin
        rd_ptr_d = '0;
        if (accept) begin
          wr_en = 1'b1;
          if (wr_ptr_q != FULL) wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_last_i || (wr_ptr_q == FULL - 1'b1)) state_d = HOLD;
        end
      end
      HOLD: begin
        // Word 0 is read on the leaving edge so sop lands one edge later.
        if (!pkt_o.busy) begin
          rd_en      = 1'b1;
          rd_addr    = '0;
          rd_first_d = 1'b1;
          rd_last_d  = (wr_ptr_q == (AWIDTH+1)'(1));
          rd_ptr_d   = (AWIDTH+1)'(1);
          state_d    = rd_last_d ? WAIT_HI : SEND;
        end
      end
      SEND: begin
        rd_en     = 1'b1;
        rd_last_d = (rd_ptr_q == wr_ptr_q - 1'b1);
        rd_ptr_d  = rd_ptr_q + 1'b1;
        if (rd_last_d) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (pkt_o.busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!pkt_o.busy) begin
          done_d   = 1'b1;
          wr_ptr_d = '0;
          state_d  = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
    ready_d = (state_d == LOAD);
    data_d  = rd_vld_q ? rd_data : data_q;
  end

`ifdef SORT_PKT_SENDER_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    pkt_cnt_d  = done_d ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    drop_cnt_d = (wr_req_i && !ready_q && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= LOAD;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      val_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      rd_vld_q   <= rd_en;
      rd_first_q <= rd_first_d;
      rd_last_q  <= rd_last_d;
      sop_q      <= rd_first_q;
      eop_q      <= rd_last_q;
      val_q      <= rd_vld_q;
      data_q     <= data_d;
    end
  end

  assign ready_o    = ready_q;
  assign done_o     = done_q;
  assign pkt_o.sop  = sop_q;
  assign pkt_o.eop  = eop_q;
  assign pkt_o.val  = val_q;
  assign pkt_o.data = data_q;

endmodule

// File: tb/tb_sort_pkt_sender.sv
// tb/tb_sort_pkt_sender.sv - directed table-driven bench for sort_pkt_sender
module tb_sort_pkt_sender;

  typedef struct {
    int         len;
    logic [7:0] d [32];
    bit         use_last;
    int         hold;
    int         lat;
    bit         extra_req;
    int         done_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       ready;
  logic       done;
  int         total = 0;
  int         bad = 0;
  int         exp_pkts = 0;
  int         exp_drops = 0;
  vec_t       vecs [5];
  vec_t       rv;
`ifdef SORT_PKT_SENDER_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;
`endif

  sort_engine_if #(.DWIDTH(8)) pkt_if ();

  sort_pkt_sender #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_req_i   (wr_req),
    .wr_data_i  (wr_data),
    .wr_last_i  (wr_last),
    .ready_o    (ready),
    .done_o     (done),
`ifdef SORT_PKT_SENDER_STATS_EN
    .pkt_cnt_o  (pkt_cnt),
    .drop_cnt_o (drop_cnt),
`endif
    .pkt_o      (pkt_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %0h want %0h", name, n, act, exp);
    end
  endtask

  task automatic chk_stats();
`ifdef SORT_PKT_SENDER_STATS_EN
    chk("pkt_cnt", 0, 32'(pkt_cnt), 32'(exp_pkts));
    chk("drop_cnt", 0, 32'(drop_cnt), 32'(exp_drops));
`endif
  endtask

  task automatic run_pkt(input vec_t v);
    int  last_n;
    bit  in_pkt;
    last_n = v.lat + v.len - 1;
    for (int i = 0; i < v.len; i++) begin
      chk("ready_load", i, 32'(ready), 32'd1);
      wr_req  = 1'b1;
      wr_data = v.d[i];
      wr_last = v.use_last && (i == v.len - 1);
      if (i == v.len - 1 && v.hold > 0) pkt_if.busy = 1'b1;
      step();
    end
    wr_req  = 1'b0;
    wr_last = 1'b0;
    wr_data = 8'h00;
    for (int n = 1; n <= last_n + 1; n++) begin
      step();
      in_pkt = (n >= v.lat) && (n <= last_n);
      chk("val", n, 32'(pkt_if.val), 32'(in_pkt));
      chk("sop", n, 32'(pkt_if.sop), 32'(n == v.lat));
      chk("eop", n, 32'(pkt_if.eop), 32'(n == last_n));
      if (in_pkt) chk("data", n, 32'(pkt_if.data), 32'(v.d[n - v.lat]));
      chk("ready_busy", n, 32'(ready), 32'd0);
      chk("done_send", n, 32'(done), 32'd0);
      if (n == v.hold) pkt_if.busy = 1'b0;
      if (v.extra_req && n == 1) begin
        wr_req  = 1'b1;
        wr_data = 8'hEE;
        exp_drops++;
      end
      if (n == 2) wr_req = 1'b0;
    end
    pkt_if.busy = 1'b1;
    for (int k = 0; k < v.done_busy; k++) begin
      step();
      chk("done_early", k, 32'(done), 32'd0);
      chk("val_idle", k, 32'(pkt_if.val), 32'd0);
      chk("data_hold", k, 32'(pkt_if.data), 32'(v.d[v.len - 1]));
    end
    pkt_if.busy = 1'b0;
    step();
    exp_pkts++;
    chk("done_pulse", 0, 32'(done), 32'd1);
    chk("ready_back", 0, 32'(ready), 32'd1);
    chk_stats();
    step();
    chk("done_once", 0, 32'(done), 32'd0);
  endtask

  initial begin
    for (int e = 0; e < 5; e++) begin
      vecs[e].len = 0;
      vecs[e].use_last = 1'b1;
      vecs[e].hold = 0;
      vecs[e].lat = 2;
      vecs[e].extra_req = 1'b0;
      vecs[e].done_busy = 3;
      for (int j = 0; j < 32; j++) vecs[e].d[j] = 8'h00;
    end
    vecs[0].len = 3;
    vecs[0].d[0] = 8'h30; vecs[0].d[1] = 8'h10; vecs[0].d[2] = 8'h20;
    vecs[0].done_busy = 40;
    vecs[1].len = 1;
    vecs[1].d[0] = 8'h55;
    vecs[2].len = 4;
    vecs[2].d[0] = 8'hA1; vecs[2].d[1] = 8'hB2; vecs[2].d[2] = 8'hC3; vecs[2].d[3] = 8'hD4;
    vecs[2].hold = 10;
    vecs[2].lat = 12;
    vecs[3].len = 32;
    vecs[3].use_last = 1'b0;
    vecs[3].extra_req = 1'b1;
    for (int j = 0; j < 32; j++) vecs[3].d[j] = 8'(j);
    vecs[4].len = 2;
    vecs[4].d[0] = 8'h9C; vecs[4].d[1] = 8'h3F;

    rst = 1'b1;
    wr_req = 1'b0;
    wr_data = 8'h00;
    wr_last = 1'b0;
    pkt_if.busy = 1'b0;
    step();
    step();
    chk("rst_sop", 0, 32'(pkt_if.sop), 32'd0);
    chk("rst_eop", 0, 32'(pkt_if.eop), 32'd0);
    chk("rst_val", 0, 32'(pkt_if.val), 32'd0);
    chk("rst_data", 0, 32'(pkt_if.data), 32'd0);
    chk("rst_ready", 0, 32'(ready), 32'd1);
    chk("rst_done", 0, 32'(done), 32'd0);
    chk_stats();
    rst = 1'b0;
    step();

    for (int e = 0; e < 4; e++) run_pkt(vecs[e]);

    // reset while word 2 of a 5-word packet is on the bus
    rv = vecs[4];
    rv.len = 5;
    for (int j = 0; j < 5; j++) rv.d[j] = 8'(8'h41 + j);
    for (int i = 0; i < 5; i++) begin
      wr_req = 1'b1;
      wr_data = rv.d[i];
      wr_last = (i == 4);
      step();
    end
    wr_req = 1'b0;
    wr_last = 1'b0;
    for (int n = 1; n <= 4; n++) step();
    chk("mid_val", 4, 32'(pkt_if.val), 32'd1);
    chk("mid_data", 4, 32'(pkt_if.data), 32'h43);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_pkts = 0;
    exp_drops = 0;
    chk("rstm_val", 0, 32'(pkt_if.val), 32'd0);
    chk("rstm_sop", 0, 32'(pkt_if.sop), 32'd0);
    chk("rstm_eop", 0, 32'(pkt_if.eop), 32'd0);
    chk("rstm_ready", 0, 32'(ready), 32'd1);
    chk("rstm_done", 0, 32'(done), 32'd0);
    chk_stats();
    run_pkt(vecs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
